// File: rtl/nios2_system_stream_pkg.sv
// Shared types and constants for the stream-to-memory writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios2_system_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BYTEEN_ALL        = 4'hF;
    localparam int         MEM_WORDS_DEFAULT = 20000;

endpackage

// File: rtl/nios2_system_stream_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x W, with flush.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module nios2_system_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/nios2_system_stream_mem_writer.sv
// Avalon-MM write master: streams 32-bit words to consecutive (wrapping) word addresses.
// Latency: stream handshake to m_write is 2 cycles; sustained 1 write/cycle with waitrequest low.
// Backpressure: s_ready drops when the skid FIFO is full or len words were already accepted; waitrequest holds the write.
module nios2_system_stream_mem_writer
    import nios2_system_stream_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic              m_waitrequest
);
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   accepted_q;

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_head;

    logic              complete;
    logic              last_cmp;
    logic              latch_start;
    logic              zero_done;
    logic              do_abort;
    logic              issue;

    assign complete     = m_write && !m_waitrequest;
    assign last_cmp     = complete && (remaining_q == (ADDR_W+1)'(1));
    assign addr_inc     = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + 1'b1;
    assign s_ready      = (state_q == RUN) && !fifo_full && (accepted_q < len_q);
    assign fifo_push    = s_valid && s_ready;
    assign busy         = (state_q == RUN);
    assign m_chipselect = m_write;
    assign m_byteenable = BYTEEN_ALL;

    nios2_system_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (do_abort),
        .push     (fifo_push),
        .push_dat (s_data),
        .pop      (issue),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and control strobes. The final completion outranks abort,
    // and abort is only honoured once no write is left outstanding.
    always_comb begin
        state_d     = state_q;
        latch_start = 1'b0;
        zero_done   = 1'b0;
        do_abort    = 1'b0;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        zero_done = 1'b1;
                    end else begin
                        latch_start = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (last_cmp) begin
                    state_d = IDLE;
                end else if (abort && (!m_write || complete)) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else if (!fifo_empty && (!m_write || complete)) begin
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, status pulses and the Avalon request registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            accepted_q  <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
        end else begin
            done    <= last_cmp || zero_done;
            aborted <= do_abort;

            if (latch_start) begin
                addr_q      <= base;
                remaining_q <= len;
                len_q       <= len;
                accepted_q  <= '0;
            end

            if (fifo_push) accepted_q <= accepted_q + 1'b1;

            if (complete) begin
                addr_q      <= addr_inc;
                remaining_q <= remaining_q - 1'b1;
            end

            // Lookahead: a write retiring this cycle hands its slot straight
            // to the next word, addressed one past the retiring one.
            if (issue) begin
                m_write     <= 1'b1;
                m_address   <= complete ? addr_inc : addr_q;
                m_writedata <= fifo_head;
            end else if (complete) begin
                m_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_system_stream_mem_writer.sv
// Scoreboard bench for the stream-to-memory writer.
// Latency: n/a.
// Backpressure: n/a.
module tb_nios2_system_stream_mem_writer;
    localparam int MW = 20000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [14:0] base;
    logic [15:0] len;
    logic        abort;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [14:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    logic        wr_rand;
    logic        wr_force;
    logic        rnd_wr;

    assign m_waitrequest = wr_rand ? rnd_wr : wr_force;

    nios2_system_stream_mem_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base          (base),
        .len           (len),
        .abort         (abort),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] dat;
    } wr_t;

    // kind: 0 = done after writes, 1 = done for len 0, 2 = aborted
    typedef struct {
        int kind;
        int cyc;
    } evt_t;

    wr_t         exp_q[$];
    evt_t        evt_q[$];
    int          cmp_cyc_q[$];
    logic [31:0] wdat [16];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_cmp_cyc = 0;
    int n_acc = 0;
    int start_cyc = 0;

    logic        prev_hold = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [31:0] prev_dat  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_wr = ($urandom_range(0, 2) == 0);
    end

    // Monitor: Avalon hold rule, write scoreboard, done/aborted events.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("byteenable", m_byteenable, 4'hF);
            chk("chipselect", m_chipselect, m_write);
            if (prev_hold) begin
                chk("hold_write", m_write, 1'b1);
                chk("hold_addr", m_address, prev_addr);
                chk("hold_data", m_writedata, prev_dat);
            end
            if (m_write && !m_waitrequest) begin
                chk("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", m_address, e.addr);
                    chk("write_data", m_writedata, e.dat);
                end
                cmp_cyc_q.push_back(cyc);
                last_cmp_cyc = cyc;
            end
            if (done || aborted) begin
                chk("event_expected", evt_q.size() != 0, 1'b1);
                if (evt_q.size() != 0) begin
                    evt_t ev;
                    ev = evt_q.pop_front();
                    chk("event_kind", aborted ? 2 : ev.kind, ev.kind);
                    chk("event_done_vs_abort", {done, aborted}, (ev.kind == 2) ? 2'b01 : 2'b10);
                    if (ev.kind == 0) begin
                        chk("done_after_last", cyc - last_cmp_cyc, 1);
                        chk("writes_left_at_done", exp_q.size(), 0);
                    end
                    if (ev.kind == 1) chk("done_len0", cyc, ev.cyc);
                end
            end
        end
        prev_hold = reset_n && m_write && m_waitrequest;
        prev_addr = m_address;
        prev_dat  = m_writedata;
    end

    // All driving tasks are entered and left at posedge+1.
    task automatic do_start(input int b, input int l, input bit push_exp);
        if (push_exp) begin
            for (int k = 0; k < l; k++) exp_q.push_back('{(b + k) % MW, wdat[k]});
            evt_q.push_back('{(l == 0) ? 1 : 0, 0});
        end
        start = 1'b1;
        base  = 15'(b);
        len   = 16'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        if (push_exp && l == 0) evt_q[evt_q.size()-1].cyc = start_cyc;
    endtask

    task automatic feed(input int first, input int n, input int gap, input int tmo);
        for (int k = first; k < first + n; k++) begin
            int  waited;
            logic acc;
            waited = 0;
            acc    = 1'b0;
            s_valid = 1'b1;
            s_data  = wdat[k];
            while (!acc && waited < tmo) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            s_valid = 1'b0;
            if (!acc) break;
            n_acc++;
            if (gap > 0) begin
                repeat ($urandom_range(0, gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_idle(input int tmo);
        int w;
        w = 0;
        while ((busy || exp_q.size() != 0 || evt_q.size() != 0) && w < tmo) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("idle_within_budget", w < tmo, 1'b1);
        chk("busy_after_idle", busy, 1'b0);
    endtask

    task automatic wait_mwrite(input int tmo);
        int w;
        w = 0;
        while (!m_write && w < tmo) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("m_write_within_budget", m_write, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; base = '0; len = '0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; wr_rand = 1'b0; wr_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_done", {done, aborted}, 2'b00);
        chk("rst_addr_data", {m_address, m_writedata}, '0);
        chk("rst_byteenable", m_byteenable, 4'hF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic: four back-to-back writes starting at address 10.
        for (int k = 0; k < 4; k++) wdat[k] = 32'hA0 + k;
        cmp_cyc_q.delete();
        n_acc = 0;
        do_start(10, 4, 1'b1);
        feed(0, 4, 0, 20);
        wait_idle(40);
        chk("basic_nwrites", cmp_cyc_q.size(), 4);
        if (cmp_cyc_q.size() == 4) chk("basic_back_to_back", cmp_cyc_q[3] - cmp_cyc_q[0], 3);

        // Stall: second write held for 3 cycles.
        for (int k = 0; k < 6; k++) wdat[k] = $urandom;
        cmp_cyc_q.delete();
        n_acc = 0;
        do_start(50, 6, 1'b1);
        fork
            feed(0, 6, 0, 30);
            begin
                int w;
                w = 0;
                while (cmp_cyc_q.size() == 0 && w < 30) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                chk("stall_first_write", cmp_cyc_q.size() != 0, 1'b1);
                wr_force = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                wr_force = 1'b0;
            end
        join
        wait_idle(60);
        chk("stall_accepted", n_acc, 6);

        // Fill: slave stalled throughout, one word in flight plus four queued.
        for (int k = 0; k < 8; k++) wdat[k] = $urandom;
        n_acc = 0;
        wr_force = 1'b1;
        do_start(500, 8, 1'b1);
        feed(0, 8, 0, 8);
        chk("fill_accepted", n_acc, 5);
        @(negedge clk);
        chk("fill_s_ready_low", s_ready, 1'b0);
        @(posedge clk);
        #1;
        wr_force = 1'b0;
        feed(5, 3, 0, 20);
        wait_idle(60);
        chk("fill_total", n_acc, 8);

        // Wrap past the top of memory.
        for (int k = 0; k < 4; k++) wdat[k] = $urandom;
        do_start(19998, 4, 1'b1);
        feed(0, 4, 1, 20);
        wait_idle(60);

        // Zero length, then overflow with len 2 and five words offered.
        do_start(123, 0, 1'b1);
        wait_idle(10);
        for (int k = 0; k < 5; k++) wdat[k] = $urandom;
        n_acc = 0;
        do_start(7, 2, 1'b1);
        feed(0, 5, 0, 10);
        chk("overflow_accepted", n_acc, 2);
        @(negedge clk);
        chk("overflow_s_ready_low", s_ready, 1'b0);
        @(posedge clk);
        #1;
        wait_idle(30);

        // Abort during a stalled write: the write completes, queued word dropped.
        wdat[0] = 32'hDEAD0001;
        wdat[1] = 32'hDEAD0002;
        exp_q.push_back('{100, wdat[0]});
        evt_q.push_back('{2, 0});
        wr_force = 1'b1;
        do_start(100, 6, 1'b0);
        feed(0, 2, 0, 10);
        wait_mwrite(10);
        abort = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("abort_waits_for_write", busy, 1'b1);
        wr_force = 1'b0;
        wait_idle(30);
        abort = 1'b0;
        wdat[0] = 32'h55;
        do_start(200, 1, 1'b1);
        feed(0, 1, 0, 10);
        wait_idle(30);

        // Reset while a write is pending.
        for (int k = 0; k < 4; k++) wdat[k] = $urandom | 32'h1;
        wr_force = 1'b1;
        do_start(300, 4, 1'b1);
        feed(0, 2, 0, 6);
        wait_mwrite(10);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_write", {m_write, m_chipselect}, 2'b00);
        chk("midrst_addr_data", {m_address, m_writedata}, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pulses", {done, aborted, s_ready}, 3'b000);
        exp_q.delete();
        evt_q.delete();
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        wr_force = 1'b0;
        @(posedge clk);
        #1;
        wdat[0] = 32'hCAFE0000;
        wdat[1] = 32'hCAFE0001;
        do_start(400, 2, 1'b1);
        @(negedge clk);
        chk("after_rst_start_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        feed(0, 2, 0, 10);
        wait_idle(30);

        // Randomized transfers with random slave stalls and stream gaps.
        wr_rand = 1'b1;
        for (int t = 0; t < 12; t++) begin
            int b;
            int l;
            b = ($urandom_range(0, 3) == 0) ? 19994 + $urandom_range(0, 5) : $urandom_range(0, MW - 1);
            l = $urandom_range(1, 8);
            for (int k = 0; k < l; k++) wdat[k] = $urandom;
            n_acc = 0;
            do_start(b, l, 1'b1);
            feed(0, l, 2, 40);
            wait_idle(200);
            chk("rand_accepted", n_acc, l);
        end
        wr_rand = 1'b0;

        repeat (3) @(posedge clk);
        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_evt_q_empty", evt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
